// File: rtl/gf2m_digit_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : gf2m_digit_feeder_if
// Description : Bundles the operand handshake, the multiplier-core bus and
//               the result handshake of the GF(2^m) digit feeder.
// Revision    : 1.0 - initial release
// ============================================================================
interface gf2m_digit_feeder_if #(
  parameter int DATA_WIDTH = 163,
  parameter int DIGITAL    = 16
);
  // Operand triple handshake
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [DATA_WIDTH-1:0] in_g;
  // Multiplier core bus
  logic                  mul_start;
  logic [DATA_WIDTH-1:0] mul_a;
  logic [DATA_WIDTH-1:0] mul_g;
  logic [DIGITAL-1:0]    mul_b;
  logic [DATA_WIDTH-1:0] mul_t;
  logic                  mul_done;
  // Result handshake and status
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  busy;

  // Environment side: supplies operands, the core response and out_ready
  modport master (
    output in_valid, in_a, in_b, in_g, mul_t, mul_done, out_ready,
    input  in_ready, mul_start, mul_a, mul_g, mul_b, out_valid, out_data, busy
  );

  // Feeder side
  modport slave (
    input  in_valid, in_a, in_b, in_g, mul_t, mul_done, out_ready,
    output in_ready, mul_start, mul_a, mul_g, mul_b, out_valid, out_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/gf2m_digit_feeder.sv
`default_nettype none
// ============================================================================
// Module      : gf2m_digit_feeder
// Description : Front-end sequencer for the digit-serial GF(2^m) multiplier.
//               Latches an operand triple, strobes the core, streams b
//               MSB-digit first, captures the core result and returns it.
// Revision    : 1.0 - initial release
// ============================================================================
module gf2m_digit_feeder #(
  parameter int DATA_WIDTH = 163,
  parameter int DIGITAL    = 16
) (
  input  logic                clk,
  input  logic                rst,   // asynchronous, active-low
  gf2m_digit_feeder_if.slave  bus
);

  localparam int NUM_DIGITS = (DATA_WIDTH + DIGITAL - 1) / DIGITAL;
  localparam int SR_W       = NUM_DIGITS * DIGITAL;
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] g_q, g_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [SR_W-1:0]       b_sr_q, b_sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      g_q     <= '0;
      res_q   <= '0;
      b_sr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      g_q     <= g_d;
      res_q   <= res_d;
      b_sr_q  <= b_sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update; b is zero-extended so the pad bits land
  // in the top of digit 0 and the shift leaves zeros behind for WAIT
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    g_d     = g_q;
    res_d   = res_q;
    b_sr_d  = b_sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          g_d     = bus.in_g;
          b_sr_d  = SR_W'(bus.in_b);
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        b_sr_d = b_sr_q << DIGITAL;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mul_done) begin
          res_d   = bus.mul_t;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come only from registers or the decoded state
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mul_start = (state_q == S_START);
  assign bus.mul_a     = a_q;
  assign bus.mul_g     = g_q;
  assign bus.mul_b     = b_sr_q[SR_W-1 -: DIGITAL];
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = res_q;

endmodule
`default_nettype wire
